ubi_stream_decode: RTL and testbench

Bipolar unary-stream-to-binary decoder: the receive end of the stochastic bitstreams produced by the team's unary multipliers and Sobol-driven encoders. It counts ones in the input stream over a fixed window of N = 2^BITWIDTH valid samples. It then returns the binary code that produced the stream, in two forms: unsigned (same format as the encoder's iB) and signed bipolar offset. It sits at the output of a uMUL_bi/uMUL chain, so results can be checked or passed on in binary.

---
 rtl/ubi_stream_decode_pkg.sv | 16 +
 rtl/ubi_window_counter.sv | 49 ++++
 rtl/ubi_stream_decode.sv | 117 +++++++++++
 tb/tb_ubi_stream_decode.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ubi_stream_decode_pkg.sv
// Shared definitions for the unary-stream decoder.
//   state_t    : FSM state encoding (IDLE, ACCUM, DONE)
//   window_len : number of valid samples in one decode window, 2^bitwidth
package ubi_stream_decode_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int window_len(input int bitwidth);
    return 1 << bitwidth;
  endfunction

endpackage

// File: rtl/ubi_window_counter.sv
// Sample and ones counters for one decode window.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : synchronous clear of both counters
//   en          : count this cycle's sample
//   sample_bit  : stream bit added to the ones count when en is high
//   samples     : valid samples captured so far (0..N)
//   ones        : ones captured so far (0..N)
//   ones_next   : ones count including this cycle's sample
//   last        : this edge captures the Nth sample of the window
module ubi_window_counter
  import ubi_stream_decode_pkg::*;
#(
  parameter int BITWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic              sample_bit,
  output logic [BITWIDTH:0] samples,
  output logic [BITWIDTH:0] ones,
  output logic [BITWIDTH:0] ones_next,
  output logic              last
);

  localparam int N = window_len(BITWIDTH);
  localparam logic [BITWIDTH:0] LAST_IDX = (BITWIDTH+1)'(N - 1);

  assign ones_next = ones + {{BITWIDTH{1'b0}}, sample_bit};
  // The FSM leaves ACCUM on this edge, so en never rises again and the
  // sample counter stops at N instead of wrapping.
  assign last      = en && (samples == LAST_IDX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samples <= '0;
      ones    <= '0;
    end else if (clr) begin
      samples <= '0;
      ones    <= '0;
    end else if (en) begin
      samples <= samples + (BITWIDTH+1)'(1);
      ones    <= ones_next;
    end
  end

endmodule

// File: rtl/ubi_stream_decode.sv
// Bipolar unary-stream-to-binary decoder. Counts ones over 2^BITWIDTH valid
// samples and presents the count, the saturated unsigned code and the
// bipolar offset value.
//   iClk, iRstN : clock, asynchronous active-low reset
//   iClr        : synchronous abort to IDLE, clears counters and results
//   iStart      : begin a window (honoured in IDLE and DONE)
//   iBit        : stream bit; iBitValid marks it as a sample
//   oBusy       : window in progress
//   oDone       : one-cycle pulse when a window completes
//   oValid      : results hold a completed window
//   oCount      : ones count 0..N
//   oBin        : min(oCount, N-1)
//   oSigned     : oCount - N/2, two's complement
module ubi_stream_decode
  import ubi_stream_decode_pkg::*;
#(
  parameter int BITWIDTH = 8
) (
  input  logic                     iClk,
  input  logic                     iRstN,
  input  logic                     iClr,
  input  logic                     iStart,
  input  logic                     iBit,
  input  logic                     iBitValid,
  output logic                     oBusy,
  output logic                     oDone,
  output logic                     oValid,
  output logic [BITWIDTH:0]        oCount,
  output logic [BITWIDTH-1:0]      oBin,
  output logic signed [BITWIDTH:0] oSigned
);

  localparam int N = window_len(BITWIDTH);
  localparam logic [BITWIDTH:0] HALF = (BITWIDTH+1)'(N / 2);

  state_t              state;
  logic                cnt_clr;
  logic                cnt_en;
  logic                cnt_last;
  logic [BITWIDTH:0]   samples;
  logic [BITWIDTH:0]   ones;
  logic [BITWIDTH:0]   ones_next;

  // A start from IDLE or DONE restarts the counters; iClr overrides everything.
  assign cnt_clr = iClr || (iStart && (state != ACCUM));
  assign cnt_en  = !iClr && (state == ACCUM) && iBitValid;

  ubi_window_counter #(.BITWIDTH(BITWIDTH)) u_counter (
    .clk        (iClk),
    .rst_n      (iRstN),
    .clr        (cnt_clr),
    .en         (cnt_en),
    .sample_bit (iBit),
    .samples    (samples),
    .ones       (ones),
    .ones_next  (ones_next),
    .last       (cnt_last)
  );

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state   <= IDLE;
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
      oValid  <= 1'b0;
      oCount  <= '0;
      oBin    <= '0;
      oSigned <= '0;
    end else if (iClr) begin
      state   <= IDLE;
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
      oValid  <= 1'b0;
      oCount  <= '0;
      oBin    <= '0;
      oSigned <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iStart) begin
            state  <= ACCUM;
            oBusy  <= 1'b1;
            oValid <= 1'b0;
          end
        end
        ACCUM: begin
          if (cnt_last) begin
            state   <= DONE;
            oBusy   <= 1'b0;
            oDone   <= 1'b1;
            oValid  <= 1'b1;
            oCount  <= ones_next;
            // Only a full count of N has the top bit set; clamp it to N-1.
            oBin    <= ones_next[BITWIDTH] ? {BITWIDTH{1'b1}} : ones_next[BITWIDTH-1:0];
            oSigned <= $signed(ones_next - HALF);
          end
        end
        DONE: begin
          oDone <= 1'b0;
          if (iStart) begin
            state  <= ACCUM;
            oBusy  <= 1'b1;
            oValid <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          oBusy <= 1'b0;
          oDone <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ubi_stream_decode.sv
// Directed testbench for ubi_stream_decode at BITWIDTH=8 (N=256).
module tb_ubi_stream_decode;

  localparam int BW = 8;
  localparam int N  = 256;

  logic              iClk = 1'b0;
  logic              iRstN;
  logic              iClr;
  logic              iStart;
  logic              iBit;
  logic              iBitValid;
  logic              oBusy;
  logic              oDone;
  logic              oValid;
  logic [BW:0]       oCount;
  logic [BW-1:0]     oBin;
  logic signed [BW:0] oSigned;

  int n_tests = 0;
  int n_fail  = 0;

  ubi_stream_decode #(.BITWIDTH(BW)) dut (
    .iClk      (iClk),
    .iRstN     (iRstN),
    .iClr      (iClr),
    .iStart    (iStart),
    .iBit      (iBit),
    .iBitValid (iBitValid),
    .oBusy     (oBusy),
    .oDone     (oDone),
    .oValid    (oValid),
    .oCount    (oCount),
    .oBin      (oBin),
    .oSigned   (oSigned)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Stream patterns indexed by valid-sample number.
  //   0 all ones, 1 all zeros, 2 alternating 1/0,
  //   3 uMUL_bi with iB=192, iA=1 (192 ones), 4 same with iA=0 (64 ones)
  function automatic logic pat(input int mode, input int idx);
    case (mode)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return (idx % 2) == 0;
      3:       return (idx % 4) != 3;
      4:       return (idx % 4) == 3;
      default: return 1'b0;
    endcase
  endfunction

  // Pulse iStart for one edge; the bit offered in that cycle must be ignored.
  task automatic start_window();
    @(negedge iClk);
    iStart = 1'b1; iBit = 1'b1; iBitValid = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
  endtask

  // Feed samples until oDone (or a budget expires). gap=1 makes every odd
  // cycle invalid with iBit=1. evt=1 reasserts iStart at sample 100,
  // evt=2 pulses iClr at sample 100 and returns right after it.
  task automatic accumulate(input int mode, input int gap, input int evt,
                            output int edges);
    int   idx;
    logic v;
    idx   = 0;
    edges = 0;
    while (edges < 2000) begin
      v         = (gap == 0) ? 1'b1 : ((edges % 2) == 1);
      iBitValid = v;
      iBit      = v ? pat(mode, idx) : 1'b1;
      iStart    = (evt == 1) && (idx == 100);
      iClr      = (evt == 2) && (idx == 100);
      if (v) idx++;
      @(negedge iClk);
      edges++;
      if (iClr) begin
        iClr = 1'b0; iBitValid = 1'b0;
        return;
      end
      if (oDone) break;
    end
    iStart = 1'b0; iBitValid = 1'b0;
  endtask

  task automatic decode(input string tag, input int mode, input int gap,
                        input int evt, input int exp_edges, input int exp_cnt);
    int edges;
    start_window();
    accumulate(mode, gap, evt, edges);
    check({tag, ".edges"}, edges, exp_edges);
    check({tag, ".done"}, oDone, 1);
    check({tag, ".valid"}, oValid, 1);
    check({tag, ".count"}, oCount, exp_cnt);
    check({tag, ".bin"}, oBin, (exp_cnt > N - 1) ? N - 1 : exp_cnt);
    check({tag, ".signed"}, oSigned, exp_cnt - N / 2);
    @(negedge iClk);
    check({tag, ".done_pulse"}, oDone, 0);
    check({tag, ".busy_after"}, oBusy, 0);
    check({tag, ".valid_hold"}, oValid, 1);
  endtask

  initial begin
    int edges;
    int seen_done;
    iRstN = 1'b0; iClr = 1'b0; iStart = 1'b0; iBit = 1'b0; iBitValid = 1'b0;
    repeat (3) @(negedge iClk);
    check("rst.busy", oBusy, 0);
    check("rst.done", oDone, 0);
    check("rst.valid", oValid, 0);
    check("rst.count", oCount, 0);
    check("rst.bin", oBin, 0);
    check("rst.signed", oSigned, 0);
    iRstN = 1'b1;
    @(negedge iClk);

    // Busy one cycle after the start edge, valid cleared.
    start_window();
    check("start.busy", oBusy, 1);
    check("start.valid", oValid, 0);
    accumulate(0, 0, 0, edges);
    check("ones.edges", edges, N);
    check("ones.count", oCount, 256);
    check("ones.bin", oBin, 255);
    check("ones.signed", oSigned, 128);
    check("ones.valid", oValid, 1);
    @(negedge iClk);
    check("ones.done_pulse", oDone, 0);

    decode("zeros", 1, 0, 0, N, 0);
    decode("alt", 2, 0, 0, N, 128);
    decode("umul_a1", 3, 0, 0, N, 192);
    decode("umul_a0", 4, 0, 0, N, 64);
    decode("gap", 0, 1, 0, 2 * N, 256);
    decode("restart_ignored", 2, 0, 1, N, 128);

    // Abort mid-window: everything returns to zero and no done follows.
    decode("pre_clr", 0, 0, 0, N, 256);
    start_window();
    accumulate(0, 0, 2, edges);
    check("clr.busy", oBusy, 0);
    check("clr.valid", oValid, 0);
    check("clr.count", oCount, 0);
    check("clr.signed", oSigned, 0);
    seen_done = 0;
    iBit = 1'b1; iBitValid = 1'b1;
    repeat (300) begin
      @(negedge iClk);
      if (oDone) seen_done = 1;
    end
    iBitValid = 1'b0;
    check("clr.no_done", seen_done, 0);

    // Back-to-back: iStart held through DONE starts the next window at once.
    start_window();
    accumulate(0, 0, 0, edges);
    check("b2b.first_count", oCount, 256);
    iStart = 1'b1; iBit = 1'b1; iBitValid = 1'b1;
    @(negedge iClk);
    iStart = 1'b0;
    check("b2b.busy", oBusy, 1);
    check("b2b.valid", oValid, 0);
    check("b2b.done", oDone, 0);
    check("b2b.count_held", oCount, 256);
    accumulate(2, 0, 0, edges);
    check("b2b.edges", edges, N);
    check("b2b.count", oCount, 128);
    check("b2b.signed", oSigned, 0);
    @(negedge iClk);

    // Async reset in the middle of a window, then a fresh decode.
    start_window();
    iBit = 1'b1; iBitValid = 1'b1;
    repeat (50) @(negedge iClk);
    #2 iRstN = 1'b0;
    #1;
    check("arst.busy", oBusy, 0);
    check("arst.valid", oValid, 0);
    check("arst.count", oCount, 0);
    check("arst.bin", oBin, 0);
    iBitValid = 1'b0;
    @(negedge iClk);
    iRstN = 1'b1;
    @(negedge iClk);
    check("arst.idle_busy", oBusy, 0);
    decode("arst_fresh", 4, 0, 0, N, 64);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
